// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

   localparam int          WORD_W  = 32;
   localparam logic [31:0] PC_INCR = 32'd4;

   // IDLE: no request on the bus
   // REQ:  request for the current pc is on the bus
   // DROP: a stale request is still outstanding; its response is thrown away
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   // One buffered fetch: the instruction word and its fetch address + 4.
   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc_plus4;
   } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO of fetched {instr, pc_plus4} entries.
// Flush outranks push and pop. A pop on an empty FIFO is ignored.
// The head entry is a plain register read, so it has no path from push_data.
module fq_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  fq_entry_t                push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output fq_entry_t                head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fq_entry_t         mem_q [DEPTH];
   fq_entry_t         mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_pop;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; reset also clears storage so the head reads zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch pc, issues one word read at a
// time to a variable-latency memory, buffers responses with pc+4, and
// flushes everything on redirect.
//
// Memory handshake: imem_req is held high with a stable imem_addr until the
// cycle imem_ack is high; imem_rdata is sampled in that same cycle. Because
// the address must stay stable, a redirect that arrives while a request is
// outstanding is parked in pend_pc and the old response is dropped.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [WORD_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [WORD_W-1:0]  imem_rdata,
   input  logic               redirect,
   input  logic [WORD_W-1:0]  redirect_pc,
   input  logic               deq,
   output logic               valid,
   output logic [WORD_W-1:0]  instr,
   output logic [WORD_W-1:0]  pc_plus4,
   output fetch_state_e       dbg_state
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e       state_q, state_d;
   logic [WORD_W-1:0]  pc_q, pc_d;
   logic [WORD_W-1:0]  pend_q, pend_d;

   logic               push;
   logic               pop;
   logic               flush;
   fq_entry_t          push_data;
   fq_entry_t          head;
   logic [CW-1:0]      count;
   logic [CW-1:0]      cnt_after;

   assign valid     = (count != '0);
   assign pop       = deq && valid && !redirect;
   assign cnt_after = count - {{(CW-1){1'b0}}, pop};
   assign push_data = '{instr: imem_rdata, pc_plus4: pc_q + PC_INCR};

   // Fetch control: next state, pc, pending redirect target, FIFO commands.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      push    = 1'b0;
      flush   = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               flush   = 1'b1;
               pc_d    = redirect_pc;
               state_d = REQ;
            end else if (cnt_after < CW'(DEPTH)) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               flush = 1'b1;
               if (imem_ack) begin
                  pc_d    = redirect_pc;
                  state_d = REQ;
               end else begin
                  pend_d  = redirect_pc;
                  state_d = DROP;
               end
            end else if (imem_ack) begin
               push = 1'b1;
               pc_d = pc_q + PC_INCR;
               // Only issue again if the slot after this push/pop is free.
               if ((cnt_after + CW'(1)) < CW'(DEPTH)) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            if (redirect) begin
               flush  = 1'b1;
               pend_d = redirect_pc;
            end
            if (imem_ack) begin
               pc_d    = redirect ? redirect_pc : pend_q;
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
      end
   end

   fq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .count     (count),
      .head      (head)
   );

   assign imem_req  = (state_q != IDLE);
   assign imem_addr = pc_q;
   assign instr     = head.instr;
   assign pc_plus4  = head.pc_plus4;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a latency-programmable memory, directed scenarios,
// random traffic, and a queue-based reference of the instruction stream.
module tb_fetch_queue;
   import fetch_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic               imem_req, imem_ack, redirect, deq, valid;
   logic [31:0]        imem_addr, imem_rdata, redirect_pc, instr, pc_plus4;
   fetch_state_e       dbg_state;

   // second instance: reset pc at the top of the address space
   logic               req2, valid2;
   logic [31:0]        addr2, instr2, pcp2;
   fetch_state_e       dbg_state2;

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
      .redirect_pc(redirect_pc), .deq(deq), .valid(valid), .instr(instr),
      .pc_plus4(pc_plus4), .dbg_state(dbg_state)
   );

   fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
      .imem_ack(req2), .imem_rdata(addr2), .redirect(1'b0),
      .redirect_pc(32'h0), .deq(1'b1), .valid(valid2), .instr(instr2),
      .pc_plus4(pcp2), .dbg_state(dbg_state2)
   );

   // ---------------- memory model ----------------
   int unsigned lat_min = 0, lat_max = 0;
   int unsigned cur_lat = 0, wait_cnt = 0, eff_lat;
   logic [31:0] data_key = 32'h0;

   always_comb begin
      eff_lat = cur_lat;
      if (eff_lat < lat_min) eff_lat = lat_min;
      if (eff_lat > lat_max) eff_lat = lat_max;
   end
   assign imem_ack   = imem_req && (wait_cnt >= eff_lat);
   assign imem_rdata = imem_addr ^ data_key;

   always @(posedge clk) begin
      if (imem_req && !imem_ack) begin
         wait_cnt <= wait_cnt + 1;
      end else begin
         wait_cnt <= 0;
         if (imem_ack) cur_lat <= $urandom_range(3, 0);
      end
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0, n_fail = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_pc = 32'h0;
   bit          stale = 1'b0;
   bit          hold_valid = 1'b0;
   logic [31:0] hold_addr = 32'h0;
   int          ack_cnt = 0;
   logic [31:0] last_ack_addr = 32'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor + reference: sampled on the falling edge, mirroring what the
   // next rising edge will do to the instruction stream.
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         exp_pc     = 32'h0;
         stale      = 1'b0;
         hold_valid = 1'b0;
      end else begin
         // address must not move while a request waits for its ack
         if (imem_req) begin
            if (hold_valid) check("addr_stable", {32'h0, imem_addr}, {32'h0, hold_addr});
            hold_valid = !imem_ack;
            hold_addr  = imem_addr;
         end else begin
            hold_valid = 1'b0;
         end
         check("valid", {63'h0, valid}, {63'h0, exp_q.size() != 0});
         if (valid && deq && !redirect && exp_q.size() != 0) begin
            check("head", {instr, pc_plus4}, exp_q.pop_front());
         end
         if (imem_ack) begin
            ack_cnt++;
            last_ack_addr = imem_addr;
         end
         if (redirect) begin
            stale = imem_req && !imem_ack;
            exp_q.delete();
            exp_pc = redirect_pc;
         end else if (imem_ack) begin
            if (stale) begin
               stale = 1'b0;
            end else begin
               check("req_addr", {32'h0, imem_addr}, {32'h0, exp_pc});
               exp_q.push_back({imem_addr ^ data_key, imem_addr + 32'd4});
               exp_pc = imem_addr + 32'd4;
            end
         end
      end
   end

   // capture the first two entries of the wrapping instance
   logic [63:0] wrap_ent [2];
   int          n_wrap = 0;
   always @(negedge clk) begin
      if (rst && valid2 && n_wrap < 2) begin
         wrap_ent[n_wrap] = {instr2, pcp2};
         n_wrap++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base;
      int k;
      deq = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

      // reset values
      tick(); tick();
      check("rst_req",   {63'h0, imem_req}, 64'h0);
      check("rst_valid", {63'h0, valid}, 64'h0);
      check("rst_addr",  {32'h0, imem_addr}, 64'h0);
      check("rst_instr", {32'h0, instr}, 64'h0);
      check("rst_pcp4",  {32'h0, pc_plus4}, 64'h0);

      // zero-wait memory, deq held: one instruction per cycle
      lat_min = 0; lat_max = 0; deq = 1'b1;
      rst = 1'b1;
      tick();
      check("first_req", {63'h0, imem_req}, 64'h1);
      tick();
      for (int i = 0; i < 8; i++) begin
         check("stream_valid", {63'h0, valid}, 64'h1);
         check("stream_instr", {32'h0, instr}, 64'(i * 4));
         check("stream_pcp4",  {32'h0, pc_plus4}, 64'(i * 4 + 4));
         tick();
      end

      // fill with deq held low
      deq = 1'b0;
      do_reset();
      base = ack_cnt;
      for (int i = 0; i < 10; i++) tick();
      check("fill_acks",  64'(ack_cnt - base), 64'd4);
      check("fill_req",   {63'h0, imem_req}, 64'h0);
      check("fill_valid", {63'h0, valid}, 64'h1);
      check("fill_head",  {32'h0, instr}, 64'h0);
      deq = 1'b1;
      tick();
      deq = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("refill_acks", 64'(ack_cnt - base), 64'd5);
      check("refill_addr", {32'h0, last_ack_addr}, 64'd16);
      check("refill_head", {32'h0, instr}, 64'd4);

      // latency 3, redirect while a request for 8 is outstanding
      lat_min = 3; lat_max = 3; deq = 1'b1;
      do_reset();
      k = 0;
      while (k < 60 && !(imem_req && imem_addr == 32'd8)) begin tick(); k++; end
      check("wait_req8", {63'h0, imem_req && imem_addr == 32'd8}, 64'h1);
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check("drop_addr",  {32'h0, imem_addr}, 64'd8);
      check("drop_valid", {63'h0, valid}, 64'h0);
      k = 0;
      while (k < 60 && !valid) begin tick(); k++; end
      check("redir_valid", {63'h0, valid}, 64'h1);
      check("redir_instr", {32'h0, instr}, 64'h100);
      check("redir_pcp4",  {32'h0, pc_plus4}, 64'h104);

      // redirect coincident with ack and deq
      lat_min = 0; lat_max = 0;
      k = 0;
      while (k < 60 && !(valid && imem_req)) begin tick(); k++; end
      check("ack_redir_pre", {63'h0, valid && imem_req}, 64'h1);
      redirect = 1'b1; redirect_pc = 32'h2000;
      tick();
      redirect = 1'b0;
      check("ack_redir_valid", {63'h0, valid}, 64'h0);
      check("ack_redir_addr",  {32'h0, imem_addr}, 64'h2000);
      tick();
      check("ack_redir_head",  {32'h0, instr}, 64'h2000);

      // reset while waiting for an ack
      lat_min = 3; lat_max = 3;
      k = 0;
      while (k < 20 && !(imem_req && !imem_ack)) begin tick(); k++; end
      rst = 1'b0;
      tick();
      check("mid_rst_req",   {63'h0, imem_req}, 64'h0);
      check("mid_rst_valid", {63'h0, valid}, 64'h0);
      check("mid_rst_addr",  {32'h0, imem_addr}, 64'h0);
      rst = 1'b1;
      k = 0;
      while (k < 60 && !valid) begin tick(); k++; end
      check("restart_instr", {32'h0, instr}, 64'h0);
      check("restart_pcp4",  {32'h0, pc_plus4}, 64'h4);

      // random traffic
      lat_min = 0; lat_max = 3;
      for (int i = 0; i < 1500; i++) begin
         if (i % 300 == 0) data_key = $urandom();
         deq      = ($urandom_range(9, 0) < 7);
         redirect = ($urandom_range(19, 0) == 0);
         redirect_pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFC : {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
         tick();
      end
      redirect = 1'b0;
      deq = 1'b1;
      for (int i = 0; i < 20; i++) tick();

      // wrap instance
      check("wrap_count",  64'(n_wrap), 64'd2);
      check("wrap_first",  wrap_ent[0], {32'hFFFF_FFFC, 32'h0});
      check("wrap_second", wrap_ent[1], {32'h0, 32'h4});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front-end between instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues word reads to a variable-latency instruction memory, one request in flight at a time. It buffers returned instructions, each with its PC+4, in a small FIFO and presents them to the IF/ID stage. It accepts redirects (taken branch, J, JR) that flush all queued and in-flight work.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0, fetch address after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-low: one clock; reset is synchronous and active-low
- imem_req  out  1  read request; held high with stable imem_addr until imem_ack
- imem_addr  out  32  word address of the current request
- imem_ack  in  1  request complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC
- deq  in  1  IF/ID consumes head entry (IFID_write & valid)
- valid  out  1  FIFO non-empty
- instr  out  32  head instruction
- pc_plus4  out  32  head entry's fetch address + 4

## Operation
- State machine: IDLE (no request), REQ (request for current pc), DROP (stale request outstanding, response discarded).
- imem_req = (state != IDLE); imem_addr = registered pc.
- IDLE -> REQ when count < DEPTH (count after this cycle's deq).
- REQ on imem_ack: push {imem_rdata, pc+4}, pc <= pc+4; stay REQ if post-push/pop count < DEPTH, else IDLE.
- redirect in IDLE: flush FIFO, pc <= redirect_pc, -> REQ.
- redirect in REQ without ack: flush, pc held on bus until ack (handshake rule), latch redirect_pc as pending, -> DROP.
- redirect in REQ with ack the same cycle: response discarded, flush, pc <= redirect_pc, -> REQ.
- DROP on imem_ack: discard data, pc <= pending pc, -> REQ. redirect in DROP: pending pc updated to newest redirect_pc; an ack in the same cycle still exits to REQ with the newest value.
- redirect outranks deq and push in the same cycle; FIFO is empty next cycle.
- deq while !valid: ignored. Push and pop in the same cycle: count unchanged.
- Only one request outstanding, and issue needs a free slot, so push never meets a full FIFO.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (rst=0 at edge): state IDLE, pc=RESET_PC, count=0, storage cleared. Outputs: imem_req=0, imem_addr=RESET_PC, valid=0, instr=0, pc_plus4=0.
- First edge with rst=1: -> REQ, so imem_req=1 in the following cycle.
- Reset mid-operation: an outstanding request is abandoned. The memory must tolerate req dropping.
- Fill latency: ack at edge N, so valid=1 and the entry at head after N.
- Zero-wait memory (ack tied to req): one instruction per cycle sustained while deq keeps up.
- Redirect at edge N: valid=0 after N; first new instruction is valid one cycle after its ack.
- instr and pc_plus4 are combinational reads of the head register. No combinational path from imem_rdata to outputs.

## Structure
- Shared package fetch_pkg: state enum (IDLE/REQ/DROP), WORD_W=32, PC_INCR=4.
- One sub-module fq_fifo: synchronous FIFO of {instr, pc_plus4}, with push/pop/flush, count, and a head read port. The top holds the FSM, pc, and pending pc.

## Test plan
- Reset then zero-wait memory returning addr as data, deq held 1 -> instr 0,4,8,… one per cycle, pc_plus4 = instr+4.
- deq held 0, DEPTH=4 -> exactly 4 acks accepted, imem_req drops to 0, valid=1 with head instr=0. One deq -> exactly one further request, at addr 16.
- Memory latency 3 cycles; redirect to 32'h100 one cycle after a request for 8 -> addr stays 8 until ack, data discarded, next request addr 32'h100, first valid pc_plus4=32'h104.
- redirect with imem_ack in the same cycle while in REQ, with deq also 1 -> FIFO empty next cycle, next request at redirect_pc, acked data never appears.
- RESET_PC=32'hFFFF_FFFC -> first entry pc_plus4=0, second request addr 0.
- Assert rst=0 while waiting for an ack -> next cycle imem_req=0, valid=0, imem_addr=RESET_PC. Fetch restarts cleanly after release.
